fifo_pop_agent: RTL and testbench

//  Read-side agent for the SRAM-backed FIFO controller: issues single-cycle pop

---
 rtl/fifo_pop_agent.sv | 157 +++++++++++++++
 tb/tb_fifo_pop_agent.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pop_agent.sv
// Read-side agent for the SRAM-backed FIFO controller: pops words, captures SRAM data, streams it out.
// Latency: pop in cycle t, word captured at end of t+1, m_valid/m_data presented from cycle t+2.
// Backpressure: a 2-entry output buffer with credit-gated pop; m_ready low stalls pop after two words.
//
// Ports: clk/rst_n; start + burst_len command (0 = drain until empty); empty/almost_empty/error
// flags and sram_q from the controller; pop request out; m_valid/m_ready/m_data stream;
// busy, done pulse, sticky err_flag (cleared by err_clr, which also leaves ERR).
module fifo_pop_agent #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              empty,
  input  logic              almost_empty,
  input  logic              error,
  input  logic [DATA_W-1:0] sram_q,
  output logic              pop,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              busy,
  output logic              done,
  output logic              err_flag,
  input  logic              err_clr
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_ERR} state_t;

  state_t            state;
  logic [LEN_W-1:0]  remaining;   // words still to be popped in a counted burst
  logic              drain;       // burst_len was 0: pop until the FIFO reports empty
  logic              inflight;    // a pop was issued last cycle; sram_q is valid now
  logic [1:0]        cnt;         // output buffer occupancy, 0..2
  logic [DATA_W-1:0] buf0;        // head entry, drives m_data directly
  logic [DATA_W-1:0] buf1;
  logic              xfer;
  logic [1:0]        occ;
  logic              credit;
  logic              last_out;

  // almost_empty is informational only; pop is gated purely by empty.
  logic unused_almost_empty;
  assign unused_almost_empty = almost_empty;

  assign m_valid = (cnt != 2'd0);
  assign m_data  = buf0;
  assign busy    = (state != S_IDLE);
  assign xfer    = m_valid && m_ready;

  // Slots committed once this edge settles: buffered + arriving - leaving.
  // Counting the word that leaves this cycle lets pop sustain one word per
  // cycle when m_ready is held high, while still never exceeding two entries.
  assign occ    = cnt + {1'b0, inflight} - {1'b0, xfer};
  assign credit = (occ < 2'd2);

  // Combinational on the current-cycle empty so a pop can never be raised
  // against an empty FIFO.
  assign pop = (state == S_RUN) && !empty && credit && (drain || (remaining != '0));

  // Buffer fully drained by the end of this cycle and nothing left to arrive.
  assign last_out = !inflight && ((cnt == 2'd0) || ((cnt == 2'd1) && xfer));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      remaining <= '0;
      drain     <= 1'b0;
      inflight  <= 1'b0;
      done      <= 1'b0;
      err_flag  <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= pop;
      if (error) begin
        err_flag <= 1'b1;
      end else if (err_clr) begin
        err_flag <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_RUN;
            remaining <= burst_len;
            drain     <= (burst_len == '0);
          end
        end
        S_RUN: begin
          if (error) begin
            state <= S_ERR;
          end else begin
            if (pop && !drain) begin
              remaining <= remaining - LEN_W'(1);
            end
            if ((pop && !drain && (remaining == LEN_W'(1))) || (drain && empty)) begin
              state <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (error) begin
            state <= S_ERR;
          end else if (last_out) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        S_ERR: begin
          if (err_clr) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Two-entry output buffer; a capture and a transfer in the same cycle
  // leave the occupancy unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= 2'd0;
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      case ({inflight, xfer})
        2'b10: begin
          if (cnt == 2'd0) begin
            buf0 <= sram_q;
          end else begin
            buf1 <= sram_q;
          end
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            buf0 <= sram_q;
          end else begin
            buf0 <= buf1;
            buf1 <= sram_q;
          end
        end
        default: ;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(inflight && !xfer && (cnt == 2'd2)));
  assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: tb/tb_fifo_pop_agent.sv
module tb_fifo_pop_agent;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [5:0] burst_len;
  logic       empty;
  logic       almost_empty;
  logic       error;
  logic [7:0] sram_q;
  logic       pop;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       busy;
  logic       done;
  logic       err_flag;
  logic       err_clr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pops = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int last_acc = 0;
  int done_cyc = 0;
  logic [7:0] seq = 8'h10;
  logic [7:0] fq[$];
  logic [7:0] expq[$];
  int popcyc[$];

  fifo_pop_agent #(.DATA_W(8), .LEN_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .burst_len(burst_len),
    .empty(empty), .almost_empty(almost_empty), .error(error), .sram_q(sram_q),
    .pop(pop), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .done(done), .err_flag(err_flag), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller model: registered flags, read data one cycle after pop.
  task automatic ctrl_model();
    logic [7:0] w;
    forever begin
      @(posedge clk);
      cyc <= cyc + 1;
      if (!rst_n) begin
        expq.delete();
      end else if (pop && (fq.size() != 0)) begin
        w = fq.pop_front();
        sram_q <= w;
        expq.push_back(w);
        pops++;
        popcyc.push_back(cyc);
      end
      empty        <= (fq.size() == 0);
      almost_empty <= (fq.size() == 1);
    end
  endtask

  // Stream scoreboard and protocol monitor, sampled on the falling edge.
  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (pop) begin
          checks++;
          if (empty) begin errors++; $display("FAIL pop_vs_empty: pop=1 with empty=%b, required empty=0", empty); end
        end
        if (m_valid && m_ready) begin
          checks++;
          acc_cnt++;
          last_acc = cyc;
          if (expq.size() == 0) begin
            errors++; $display("FAIL stream_extra: got word %h, expected no word", m_data);
          end else begin
            e = expq.pop_front();
            if (m_data !== e) begin errors++; $display("FAIL stream_data: got %h expected %h", m_data, e); end
          end
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic load(input int n);
    fq.delete();
    popcyc.delete();
    for (int i = 0; i < n; i++) begin fq.push_back(seq); seq = seq + 8'd7; end
    tick(2);
  endtask

  task automatic start_burst(input int len, output int st);
    burst_len = 6'(len);
    start = 1'b1;
    st = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      tick(1);
      if (!busy) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    checks++; if (pop !== 1'b0) begin errors++; $display("FAIL rst_pop: got %b expected 0", pop); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b expected 0", m_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
    checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL rst_err_flag: got %b expected 0", err_flag); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL rst_m_data: got %h expected 00", m_data); end
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_burst3();
    int st, p0, a0, d0; bit ok;
    load(5);
    m_ready = 1'b1;
    p0 = pops; a0 = acc_cnt; d0 = done_cnt;
    start_burst(3, st);
    wait_idle(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b3_timeout: busy=%b expected 0", busy); end
    tick(2);
    checks++; if (pops - p0 !== 3) begin errors++; $display("FAIL b3_pops: got %0d expected 3", pops - p0); end
    checks++;
    if (popcyc.size() !== 3) begin
      errors++; $display("FAIL b3_pop_cycles: got %0d pop records expected 3", popcyc.size());
    end else if (popcyc[0] !== st + 1 || popcyc[2] !== st + 3) begin
      errors++; $display("FAIL b3_pop_cycles: got first=%0d last=%0d expected %0d and %0d", popcyc[0], popcyc[2], st + 1, st + 3);
    end
    checks++; if (acc_cnt - a0 !== 3) begin errors++; $display("FAIL b3_accepts: got %0d expected 3", acc_cnt - a0); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL b3_done_count: got %0d expected 1", done_cnt - d0); end
    checks++; if (done_cyc !== st + 6 || last_acc !== st + 5) begin errors++; $display("FAIL b3_done_timing: got done=%0d last_acc=%0d expected %0d and %0d", done_cyc, last_acc, st + 6, st + 5); end
    checks++; if (fq.size() !== 2) begin errors++; $display("FAIL b3_left_in_fifo: got %0d expected 2", fq.size()); end
  endtask

  task automatic test_drain();
    int st, p0, a0, d0; bit ok;
    load(4);
    m_ready = 1'b1;
    p0 = pops; a0 = acc_cnt; d0 = done_cnt;
    start_burst(0, st);
    wait_idle(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL drain_timeout: busy=%b expected 0", busy); end
    tick(2);
    checks++; if (pops - p0 !== 4) begin errors++; $display("FAIL drain_pops: got %0d expected 4", pops - p0); end
    checks++; if (acc_cnt - a0 !== 4) begin errors++; $display("FAIL drain_accepts: got %0d expected 4", acc_cnt - a0); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL drain_done: got %0d expected 1", done_cnt - d0); end
    // Drain of an already empty FIFO still completes with a done pulse.
    load(0);
    p0 = pops; d0 = done_cnt;
    start_burst(0, st);
    wait_idle(20, ok);
    tick(2);
    checks++; if (!ok || done_cnt - d0 !== 1) begin errors++; $display("FAIL drain0_done: got %0d pulses idle=%b expected 1 pulse idle=1", done_cnt - d0, ok); end
    checks++; if (pops - p0 !== 0) begin errors++; $display("FAIL drain0_pops: got %0d expected 0", pops - p0); end
  endtask

  task automatic test_backpressure();
    int st, p0, a0, d0; bit ok;
    load(8);
    m_ready = 1'b0;
    p0 = pops; a0 = acc_cnt; d0 = done_cnt;
    start_burst(6, st);
    tick(10);
    checks++; if (pops - p0 !== 2) begin errors++; $display("FAIL bp_stall_pops: got %0d expected 2", pops - p0); end
    checks++; if (m_valid !== 1'b1 || pop !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL bp_stall_state: got valid=%b pop=%b busy=%b expected 1 0 1", m_valid, pop, busy); end
    m_ready = 1'b1;
    wait_idle(60, ok);
    tick(2);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: busy=%b expected 0", busy); end
    checks++; if (pops - p0 !== 6 || acc_cnt - a0 !== 6) begin errors++; $display("FAIL bp_counts: got pops=%0d accepts=%0d expected 6 6", pops - p0, acc_cnt - a0); end
    checks++; if (done_cnt - d0 !== 1 || expq.size() !== 0) begin errors++; $display("FAIL bp_done: got done=%0d pending=%0d expected 1 0", done_cnt - d0, expq.size()); end
  endtask

  task automatic test_refill();
    int st, p0, a0, d0; bit ok;
    load(2);
    m_ready = 1'b1;
    p0 = pops; a0 = acc_cnt; d0 = done_cnt;
    start_burst(4, st);
    tick(10);
    checks++; if (pops - p0 !== 2 || pop !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL refill_wait: got pops=%0d pop=%b busy=%b expected 2 0 1", pops - p0, pop, busy); end
    fq.push_back(8'hA5);
    fq.push_back(8'h5A);
    wait_idle(40, ok);
    tick(2);
    checks++; if (!ok || pops - p0 !== 4) begin errors++; $display("FAIL refill_pops: got %0d idle=%b expected 4 idle=1", pops - p0, ok); end
    checks++; if (acc_cnt - a0 !== 4 || done_cnt - d0 !== 1) begin errors++; $display("FAIL refill_done: got accepts=%0d done=%0d expected 4 1", acc_cnt - a0, done_cnt - d0); end
  endtask

  task automatic test_error();
    int st, p0, a0, d0;
    load(6);
    m_ready = 1'b0;
    a0 = acc_cnt; d0 = done_cnt;
    start_burst(5, st);
    tick(3);
    error = 1'b1;
    tick(1);
    error = 1'b0;
    p0 = pops;
    tick(4);
    checks++; if (pops - p0 !== 0 || pop !== 1'b0) begin errors++; $display("FAIL err_pop: got %0d extra pops pop=%b expected 0 0", pops - p0, pop); end
    checks++; if (err_flag !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL err_flag: got err_flag=%b busy=%b expected 1 1", err_flag, busy); end
    m_ready = 1'b1;
    tick(4);
    checks++; if (acc_cnt - a0 !== 2 || m_valid !== 1'b0) begin errors++; $display("FAIL err_drain: got accepts=%0d valid=%b expected 2 0", acc_cnt - a0, m_valid); end
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(2);
    checks++; if (busy !== 1'b0 || err_flag !== 1'b0) begin errors++; $display("FAIL err_clr: got busy=%b err_flag=%b expected 0 0", busy, err_flag); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL err_no_done: got %0d pulses expected 0", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int st, p0, a0, d0; bit ok;
    load(6);
    m_ready = 1'b0;
    d0 = done_cnt;
    start_burst(5, st);
    tick(2);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid: got %b expected 1", m_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if ({pop, m_valid, busy, done, err_flag} !== 5'b0 || m_data !== 8'h00) begin errors++; $display("FAIL rstmid_outputs: got pop,valid,busy,done,err=%b data=%h expected 00000 00", {pop, m_valid, busy, done, err_flag}, m_data); end
    tick(2);
    rst_n = 1'b1;
    tick(1);
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d expected 0", done_cnt - d0); end
    load(3);
    m_ready = 1'b1;
    p0 = pops; a0 = acc_cnt; d0 = done_cnt;
    start_burst(3, st);
    wait_idle(40, ok);
    tick(2);
    checks++; if (!ok || pops - p0 !== 3 || acc_cnt - a0 !== 3) begin errors++; $display("FAIL rstmid_rerun: got pops=%0d accepts=%0d idle=%b expected 3 3 1", pops - p0, acc_cnt - a0, ok); end
    checks++; if (done_cnt - d0 !== 1 || expq.size() !== 0) begin errors++; $display("FAIL rstmid_rerun_done: got done=%0d pending=%0d expected 1 0", done_cnt - d0, expq.size()); end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    burst_len = '0;
    empty = 1'b1;
    almost_empty = 1'b0;
    error = 1'b0;
    sram_q = '0;
    m_ready = 1'b0;
    err_clr = 1'b0;
    fork
      ctrl_model();
      monitor();
    join_none
    test_reset();
    test_burst3();
    test_drain();
    test_backpressure();
    test_refill();
    test_error();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
